// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS core: datapath width, opcodes, fetch FSM
// encoding and the branch offset helper.
package mips_pkg;

  localparam int XLEN = 32;

  localparam logic [5:0] OP_R   = 6'b000000;
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_SW  = 6'b101011;
  localparam logic [5:0] OP_BEQ = 6'b000100;
  localparam logic [5:0] OP_J   = 6'b000010;

  typedef enum logic {
    ST_FETCH = 1'b0,
    ST_EXEC  = 1'b1
  } fetch_state_e;

  // Word-granular branch displacement: sign-extended imm16 shifted left by two.
  function automatic logic [XLEN-1:0] branch_offset(input logic [15:0] imm);
    return {{(XLEN-18){imm[15]}}, imm, 2'b00};
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction memory read port: request/address out, ack/data back.
interface fetch_unit_if;
  import mips_pkg::*;

  logic            req;
  logic [XLEN-1:0] addr;
  logic            ack;
  logic [XLEN-1:0] rdata;

  modport master (output req, addr, input ack, rdata);
  modport slave  (input req, addr, output ack, rdata);

endinterface

// File: rtl/next_pc_logic.sv
// Combinational next-PC selection: jump target, taken branch, or fall-through.
module next_pc_logic
  import mips_pkg::*;
(
  input  logic [XLEN-1:0] pc_plus4,
  input  logic [XLEN-1:0] inst,
  input  logic            Branch,
  input  logic            JMP,
  input  logic            zero,
  output logic [XLEN-1:0] next_pc
);

  logic [XLEN-1:0] jump_target;
  logic [XLEN-1:0] branch_target;
  logic            unused_opcode;

  assign jump_target   = {pc_plus4[31:28], inst[25:0], 2'b00};
  assign branch_target = pc_plus4 + branch_offset(inst[15:0]);
  assign unused_opcode = ^inst[31:26];

  // Jump has priority over a taken branch.
  always_comb begin
    next_pc = pc_plus4;
    if (JMP) begin
      next_pc = jump_target;
    end else if (Branch && zero) begin
      next_pc = branch_target;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC register, variable-latency imem fetch, and
// instruction retirement with branch/jump redirection.
module fetch_unit
  import mips_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            rst,
  fetch_unit_if.master    imem,
  output logic [XLEN-1:0] inst,
  output logic [5:0]      op,
  output logic            inst_valid,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_plus4,
  input  logic            Branch,
  input  logic            JMP,
  input  logic            zero,
  input  logic            stall,
  output logic [XLEN-1:0] retired
);

  localparam logic [XLEN-1:0] PC_INIT = {RESET_PC[XLEN-1:2], 2'b00};

  fetch_state_e    state_reg, state_next;
  logic [XLEN-1:0] pc_reg, pc_next;
  logic [XLEN-1:0] inst_reg, inst_next;
  logic [XLEN-1:0] retired_reg, retired_next;
  logic [XLEN-1:0] pc_plus4_w;
  logic [XLEN-1:0] next_pc;

  assign pc_plus4_w = pc_reg + 32'd4;

  next_pc_logic u_next_pc (
    .pc_plus4 (pc_plus4_w),
    .inst     (inst_reg),
    .Branch   (Branch),
    .JMP      (JMP),
    .zero     (zero),
    .next_pc  (next_pc)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= ST_FETCH;
      pc_reg      <= PC_INIT;
      inst_reg    <= '0;
      retired_reg <= '0;
    end else begin
      state_reg   <= state_next;
      pc_reg      <= pc_next;
      inst_reg    <= inst_next;
      retired_reg <= retired_next;
    end
  end

  // Ack is only honoured while requesting; control inputs only while executing.
  always_comb begin
    state_next   = state_reg;
    pc_next      = pc_reg;
    inst_next    = inst_reg;
    retired_next = retired_reg;
    case (state_reg)
      ST_FETCH: begin
        if (imem.ack) begin
          inst_next  = imem.rdata;
          state_next = ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (!stall) begin
          pc_next      = next_pc;
          retired_next = retired_reg + 32'd1;
          state_next   = ST_FETCH;
        end
      end
      default: state_next = ST_FETCH;
    endcase
  end

  assign imem.req   = (state_reg == ST_FETCH);
  assign imem.addr  = pc_reg;
  assign inst       = inst_reg;
  assign op         = inst_reg[31:26];
  assign inst_valid = (state_reg == ST_EXEC);
  assign pc         = pc_reg;
  assign pc_plus4   = pc_plus4_w;
  assign retired    = retired_reg;

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage for the MIPS core: holds the PC, fetches from a variable-latency instruction memory, and presents the current instruction (with its `op` field) to the main control decoder and datapath. It consumes the decoder's `Branch` and `JMP` outputs plus the ALU `zero` flag to pick the next PC, so it sits directly upstream and downstream of control decode.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC after reset; bits [1:0] are forced to 0.
- `clk`  in  1: single clock, rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `imem_req`  out  1: instruction read request.
- `imem_addr`  out  32: byte address of the read, equal to `pc`.
- `imem_ack`  in  1: read complete; `imem_rdata` is valid in this cycle.
- `imem_rdata`  in  32: instruction word.
- `inst`  out  32: registered current instruction.
- `op`  out  6: `inst[31:26]`, feeds control decode.
- `inst_valid`  out  1: `inst` holds a fetched, not-yet-retired instruction.
- `pc`  out  32: address of `inst`.
- `pc_plus4`  out  32: `pc + 4`, mod 2^32.
- `Branch`  in  1: from control decode.
- `JMP`  in  1: from control decode.
- `zero`  in  1: ALU zero flag.
- `stall`  in  1: core cannot retire `inst` this cycle.
- `retired`  out  32: count of retired instructions.

## Operation
- FSM, two states: FETCH and EXEC.
- FETCH: `imem_req`=1, `imem_addr`=`pc`. If `imem_ack`=1, capture `imem_rdata` into `inst` and go to EXEC. Otherwise stay in FETCH with `req` held and the address stable.
- EXEC: `inst_valid`=1, `imem_req`=0. If `stall`=0, the instruction retires: `pc` <= `next_pc`, `retired` += 1 (wraps at 2^32), and the FSM goes to FETCH. If `stall`=1, hold all state.
- `next_pc` uses the values of `JMP`, `Branch` and `zero` in the retiring cycle:
  - JMP=1: `{pc_plus4[31:28], inst[25:0], 2'b00}`. JMP wins over Branch.
  - Branch=1 and zero=1: `pc_plus4 + (sign_extend(inst[15:0]) << 2)`, 32-bit wrap.
  - Otherwise: `pc_plus4`.
- `imem_ack` is ignored in EXEC and whenever `imem_req`=0.
- `Branch`, `JMP`, `zero` and `stall` are ignored in FETCH.
- `pc[1:0]` is always 00.

## Timing
- Reset values (rst=1 at an edge):
  - state = FETCH
  - `pc` = `RESET_PC & ~3`
  - `inst` = 0, `inst_valid` = 0, `retired` = 0
  - `imem_req` is 1 in the first cycle after reset
- Minimum throughput is 2 cycles per instruction: ack in cycle N, EXEC in N+1, retire in N+1, new request in N+2.
- `inst_valid` rises the cycle after ack and falls the cycle after retire.
- `op`, `pc` and `pc_plus4` are stable throughout EXEC.
- Reset mid-fetch: an outstanding request is abandoned. An ack arriving in the reset cycle is dropped, and the request restarts at `RESET_PC`.
- Reset in EXEC: no retire, and `retired` is not incremented.
- `stall` and a branch held together: nothing changes until `stall`=0. The branch is then evaluated with that cycle's inputs.

## Structure
- Shared package `mips_pkg`:
  - opcode constants: R=6'b000000, LW=6'b100011, SW=6'b101011, BEQ=6'b000100, J=6'b000010
  - FSM state encoding
  - width constant 32
- One combinational sub-module, `next_pc_logic`: inputs `pc_plus4`, `inst`, `Branch`, `JMP`, `zero`; output `next_pc`.
- The FSM, PC register, instruction register and counter live in `fetch_unit`.

## Test plan
- Reset then ack after 3 cycles with rdata=32'h2008_0005: `imem_addr`=0 during the wait; `inst_valid`=1 one cycle after ack; `op`=6'b001000; retire gives `pc`=4 and `retired`=1.
- BEQ at pc=0x40, inst=32'h1000_FFFE, Branch=1, zero=1: next `imem_addr`=0x3C. Same case with zero=0: next `imem_addr`=0x44.
- J at pc=0x1000_0010, inst=32'h0800_0100: next `imem_addr`=0x1000_0400. With Branch=1 and zero=1 as well, JMP still wins.
- `stall`=1 for 4 EXEC cycles: `pc`, `inst` and `retired` unchanged and `imem_req`=0; retire occurs on the first cycle with `stall`=0.
- `rst` asserted in the same cycle as `imem_ack`: `inst_valid` stays 0 and the next request goes to `RESET_PC`. A spurious `imem_ack` in EXEC leaves `inst` unchanged.
- Sequential run to pc=0xFFFF_FFFC: `pc_plus4` wraps to 0, and the next fetch address is 0.
